output_bram_drain: RTL and testbench
====================================

OUTPUT_BRAM_DRAIN -- requirements
Module: output_bram_drain

Interface
REQ-001 SHALL have parameter DW, default 16, meaning the output word width in bits.
REQ-002 SHALL have parameter NUM_BRAMS, default 16, meaning the number of output BRAM lanes per row.
REQ-003 SHALL have parameter O_ADDR_WIDTH, default 9, meaning the output BRAM address width (depth 2^O_ADDR_WIDTH).
REQ-004 SHALL have port clk, input, width 1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, width 1: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, width 1: a one-cycle pulse that launches a drain.
REQ-007 SHALL have port base_addr, input, width O_ADDR_WIDTH: the first row address, sampled on an accepted start.
REQ-008 SHALL have port num_rows, input, width O_ADDR_WIDTH+1: the number of rows to drain (0..2^O_ADDR_WIDTH), sampled on an accepted start.
REQ-009 SHALL have port ext_read_mode, output, width 1: external read enable to the output BRAM array.
REQ-010 SHALL have port ext_read_addr_flat, output, width NUM_BRAMS*O_ADDR_WIDTH: per-lane read address; every lane carries the same value.
REQ-011 SHALL have port bram_read_data_flat, input, width NUM_BRAMS*DW: the row read back from the BRAMs; lane k occupies bits [k*DW +: DW].
REQ-012 SHALL have port m_data, output, width DW: stream data.
REQ-013 SHALL have port m_valid, output, width 1: stream valid.
REQ-014 SHALL have port m_ready, input, width 1: stream ready from the consumer.
REQ-015 SHALL have port m_last, output, width 1: marks the final word of a drain.
REQ-016 SHALL have port busy, output, width 1: high whenever the block is not IDLE.
REQ-017 SHALL have port done, output, width 1: a one-cycle pulse when a drain completes.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, CAPTURE, SEND and DONE.
REQ-019 SHALL, in IDLE, accept start and latch cur_addr=base_addr and rows_left=num_rows, then go to ISSUE if num_rows!=0, else go to DONE.
REQ-020 SHALL ignore start while busy=1.
REQ-021 SHALL drive ext_read_mode=1 in every state except IDLE, with ext_read_addr_flat = NUM_BRAMS copies of cur_addr.
REQ-022 SHALL spend exactly one cycle in ISSUE, in which the address is presented, then go to CAPTURE.
REQ-023 SHALL, in CAPTURE, register bram_read_data_flat into a row buffer (one-cycle BRAM read latency), set lane_idx=0, then go to SEND.
REQ-024 SHALL, in SEND, assert m_valid=1 with m_data = row buffer lane lane_idx, and hold m_data stable until m_valid&&m_ready.
REQ-025 SHALL, on each SEND handshake with lane_idx<NUM_BRAMS-1, increment lane_idx.
REQ-026 SHALL, on the SEND handshake with lane_idx=NUM_BRAMS-1, decrement rows_left, then go to DONE if rows_left was 1; otherwise increment cur_addr modulo 2^O_ADDR_WIDTH (so 511 wraps to 0) and go to ISSUE.
REQ-027 SHALL assert m_last only in SEND, when lane_idx=NUM_BRAMS-1 and rows_left=1.
REQ-028 SHALL, in DONE, pulse done=1 for one cycle and return to IDLE; a start in the DONE cycle is ignored.
REQ-029 SHALL keep m_valid=0 outside SEND and leave the word order unaffected by m_ready stalls of any length.
REQ-030 SHALL reach a steady-state cost of NUM_BRAMS+2 cycles per row with m_ready held high.

Reset
REQ-031 SHALL, on rst_n=0 (asynchronous, including mid-drain), force state=IDLE and ext_read_mode=0, ext_read_addr_flat=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, row buffer=0, counters=0; the partial drain is abandoned.

Configuration
REQ-032 SHALL, when macro OUTPUT_DRAIN_RELU_EN is defined, output m_data=0 for any lane word whose sign bit is 1 (signed ReLU), passing non-negative words unchanged.
REQ-033 SHALL, without OUTPUT_DRAIN_RELU_EN, pass the lane word unmodified.

Structure
REQ-034 SHALL place the FSM state encoding and the default DW/NUM_BRAMS/O_ADDR_WIDTH constants in the shared package used by the output-BRAM blocks.
REQ-035 SHALL contain one sub-module, drain_relu (a DW-wide combinational ReLU/bypass selected by the macro); everything else is flat.

Verification
REQ-036 SHALL verify: start with base_addr=0, num_rows=1, m_ready=1, BRAM lane k=k+1 -> m_data 1..16 over 16 cycles, m_last on 16, done 1 cycle later, addr 0 presented.
REQ-037 SHALL verify: num_rows=3, base_addr=510 -> addresses 510, 511, 0 presented in order, 48 words out, one m_last.
REQ-038 SHALL verify: m_ready toggled at random with a 50% duty -> word sequence identical to the m_ready=1 case, and m_data never changes while m_valid&&!m_ready.
REQ-039 SHALL verify: num_rows=0 -> no ext_read_mode assertion, no m_valid, done pulses one cycle after start.
REQ-040 SHALL verify: rst_n dropped after 5 words of a 2-row drain -> all outputs 0 immediately; a new start afterwards drains correctly from base_addr.
REQ-041 SHALL verify: lane value 16'hFFF0 -> m_data 16'h0000 with OUTPUT_DRAIN_RELU_EN defined, and 16'hFFF0 without it.

Source files
------------

// File: rtl/output_bram_drain_pkg.sv
// Shared definitions for the output-BRAM blocks: default geometry constants
// and the drain FSM state encoding.
package output_bram_drain_pkg;

  // Default geometry of the output BRAM array.
  localparam int DRAIN_DW           = 16;
  localparam int DRAIN_NUM_BRAMS    = 16;
  localparam int DRAIN_O_ADDR_WIDTH = 9;

  // Drain FSM states.
  //   ST_IDLE    : waiting for start
  //   ST_ISSUE   : row address presented to the BRAMs
  //   ST_CAPTURE : BRAM read data registered into the row buffer
  //   ST_SEND    : row buffer streamed out one lane per handshake
  //   ST_DONE    : one-cycle completion pulse
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Width of a lane index able to address n lanes (at least one bit).
  function automatic int lane_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_bram_drain_relu.sv
// drain_relu: DW-wide combinational word filter on the drain output path.
// With OUTPUT_DRAIN_RELU_EN defined, words with the sign bit set are
// replaced by zero (signed ReLU); otherwise the word passes unchanged.
module drain_relu #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] word_i,
  output logic [DW-1:0] word_o
);

`ifdef OUTPUT_DRAIN_RELU_EN
  // Clamp negative two's-complement words to zero.
  always_comb begin
    word_o = word_i;
    if (word_i[DW-1]) begin
      word_o = '0;
    end
  end
`else
  // Bypass: the lane word is forwarded untouched.
  always_comb begin
    word_o = word_i;
  end
`endif

endmodule

// File: rtl/output_bram_drain.sv
// output_bram_drain: reads rows from the output BRAM array (one address
// shared by all lanes) and streams each row out lane by lane over a
// valid/ready interface.
//
// Build option: OUTPUT_DRAIN_RELU_EN enables the signed ReLU on the stream.
//
// Stream handshake: a word transfers on a rising edge where m_valid and
// m_ready are both 1. Once m_valid is raised, m_valid, m_data and m_last
// stay constant until that transfer; m_valid never depends on m_ready.
//
// Row timing: ISSUE (address out) -> CAPTURE (BRAM data, one-cycle read
// latency, registered) -> SEND (NUM_BRAMS words), i.e. NUM_BRAMS+2 cycles
// per row when m_ready stays high.
module output_bram_drain
  import output_bram_drain_pkg::*;
#(
  parameter int DW           = DRAIN_DW,
  parameter int NUM_BRAMS    = DRAIN_NUM_BRAMS,
  parameter int O_ADDR_WIDTH = DRAIN_O_ADDR_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [O_ADDR_WIDTH-1:0]        base_addr,
  input  logic [O_ADDR_WIDTH:0]          num_rows,
  output logic                           ext_read_mode,
  output logic [NUM_BRAMS*O_ADDR_WIDTH-1:0] ext_read_addr_flat,
  input  logic [NUM_BRAMS*DW-1:0]        bram_read_data_flat,
  output logic [DW-1:0]                  m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_last,
  output logic                           busy,
  output logic                           done,
  output state_e                         dbg_state
);

  localparam int LANE_W = lane_idx_width(NUM_BRAMS);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_BRAMS - 1);
  localparam logic [O_ADDR_WIDTH:0] ONE_ROW = (O_ADDR_WIDTH + 1)'(1);

  state_e                    state_q, state_d;
  logic [O_ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [O_ADDR_WIDTH:0]     rows_left_q, rows_left_d;
  logic [LANE_W-1:0]         lane_idx_q, lane_idx_d;
  logic [NUM_BRAMS*DW-1:0]   row_buf_q, row_buf_d;
  // Set when the accepted drain had zero rows: no BRAM access at all.
  logic                      empty_q, empty_d;

  logic [DW-1:0]             lane_word;
  logic [DW-1:0]             lane_word_filt;
  logic                      last_lane;
  logic                      last_row;

  assign lane_word = row_buf_q[lane_idx_q*DW +: DW];
  assign last_lane = (lane_idx_q == LAST_LANE);
  assign last_row  = (rows_left_q == ONE_ROW);

  drain_relu #(
    .DW (DW)
  ) u_relu (
    .word_i (lane_word),
    .word_o (lane_word_filt)
  );

  // State and datapath registers; reset abandons any drain in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      rows_left_q <= '0;
      lane_idx_q  <= '0;
      row_buf_q   <= '0;
      empty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      rows_left_q <= rows_left_d;
      lane_idx_q  <= lane_idx_d;
      row_buf_q   <= row_buf_d;
      empty_q     <= empty_d;
    end
  end

  // Next-state and datapath update for the drain sequence.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    rows_left_d = rows_left_q;
    lane_idx_d  = lane_idx_q;
    row_buf_d   = row_buf_q;
    empty_d     = empty_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_addr_d  = base_addr;
          rows_left_d = num_rows;
          lane_idx_d  = '0;
          empty_d     = (num_rows == '0);
          state_d     = (num_rows == '0) ? ST_DONE : ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        row_buf_d  = bram_read_data_flat;
        lane_idx_d = '0;
        state_d    = ST_SEND;
      end

      ST_SEND: begin
        if (m_ready) begin
          if (!last_lane) begin
            lane_idx_d = lane_idx_q + LANE_W'(1);
          end else begin
            rows_left_d = rows_left_q - ONE_ROW;
            if (last_row) begin
              state_d = ST_DONE;
            end else begin
              // Address wraps naturally at 2^O_ADDR_WIDTH.
              cur_addr_d = cur_addr_q + O_ADDR_WIDTH'(1);
              state_d    = ST_ISSUE;
            end
          end
        end
      end

      ST_DONE: begin
        // A start arriving here is deliberately dropped.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    ext_read_mode      = 1'b0;
    ext_read_addr_flat = '0;
    m_valid            = 1'b0;
    m_data             = '0;
    m_last             = 1'b0;
    busy               = (state_q != ST_IDLE);
    done               = (state_q == ST_DONE);

    unique case (state_q)
      ST_ISSUE, ST_CAPTURE: begin
        ext_read_mode = 1'b1;
      end
      ST_SEND: begin
        ext_read_mode = 1'b1;
        m_valid       = 1'b1;
        m_data        = lane_word_filt;
        m_last        = last_lane && last_row;
      end
      ST_DONE: begin
        // An empty drain never touches the BRAM array.
        ext_read_mode = !empty_q;
      end
      default: begin
        ext_read_mode = 1'b0;
      end
    endcase

    if (ext_read_mode) begin
      ext_read_addr_flat = {NUM_BRAMS{cur_addr_q}};
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_output_bram_drain.sv
// Testbench for output_bram_drain: behavioural BRAM array, randomized
// stream back-pressure, and a reference model that predicts the word
// stream, row addresses and timing from the drain rules.
module tb_output_bram_drain;

  localparam int DW    = 16;
  localparam int NB    = 16;
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;
  localparam int ROW_CYC = NB + 2;

`ifdef OUTPUT_DRAIN_RELU_EN
  localparam logic [DW-1:0] RELU_EXP = 16'h0000;
`else
  localparam logic [DW-1:0] RELU_EXP = 16'hFFF0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [AW-1:0]        base_addr;
  logic [AW:0]          num_rows;
  logic                 ext_read_mode;
  logic [NB*AW-1:0]     ext_read_addr_flat;
  logic [NB*DW-1:0]     bram_read_data_flat;
  logic [DW-1:0]        m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;
  logic                 busy;
  logic                 done;
  output_bram_drain_pkg::state_e dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  output_bram_drain #(
    .DW           (DW),
    .NUM_BRAMS    (NB),
    .O_ADDR_WIDTH (AW)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .base_addr           (base_addr),
    .num_rows            (num_rows),
    .ext_read_mode       (ext_read_mode),
    .ext_read_addr_flat  (ext_read_addr_flat),
    .bram_read_data_flat (bram_read_data_flat),
    .m_data              (m_data),
    .m_valid             (m_valid),
    .m_ready             (m_ready),
    .m_last              (m_last),
    .busy                (busy),
    .done                (done),
    .dbg_state           (dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- behavioural BRAM array ----------------
  logic [DW-1:0] mem [0:DEPTH-1][0:NB-1];

  // One-cycle registered read while the drain holds read mode.
  initial begin
    logic [NB*DW-1:0] row;
    bram_read_data_flat = '0;
    forever begin
      @(posedge clk);
      if (ext_read_mode) begin
        for (int k = 0; k < NB; k++) row[k*DW +: DW] = mem[ext_read_addr_flat[AW-1:0]][k];
        bram_read_data_flat <= row;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] exp_q[$];
  int            exp_addr_q[$];

  function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] w);
`ifdef OUTPUT_DRAIN_RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  task automatic build_expect(input int base, input int rows);
    exp_q.delete();
    exp_addr_q.delete();
    for (int r = 0; r < rows; r++) begin
      int a;
      a = (base + r) % DEPTH;
      exp_addr_q.push_back(a);
      for (int k = 0; k < NB; k++) exp_q.push_back(ref_word(mem[a][k]));
    end
  endtask

  // ---------------- monitor ----------------
  int            cyc = 0;
  int            hs_count, last_count, valid_count, rd_count, done_count;
  int            done_cyc, first_hs_cyc, start_cyc;
  int            addr_log[$];
  logic          lane_addr_bad;
  logic [DW-1:0] first_word;
  logic          prev_stall, prev_rd;
  logic [DW-1:0] prev_data;
  int            prev_addr;
  logic          rand_ready = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic clear_mon();
    hs_count = 0; last_count = 0; valid_count = 0; rd_count = 0; done_count = 0;
    done_cyc = -1; first_hs_cyc = -1;
    addr_log.delete();
    lane_addr_bad = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] exp_w;
    int a0;
    prev_stall = 1'b0; prev_rd = 1'b0; prev_data = '0; prev_addr = 0;
    clear_mon();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        prev_rd    = 1'b0;
      end else begin
        if (ext_read_mode) begin
          rd_count++;
          a0 = int'(ext_read_addr_flat[AW-1:0]);
          for (int k = 1; k < NB; k++)
            if (int'(ext_read_addr_flat[k*AW +: AW]) != a0) lane_addr_bad = 1'b1;
          if (!prev_rd || a0 != prev_addr) addr_log.push_back(a0);
          prev_addr = a0;
        end
        prev_rd = ext_read_mode;
        if (prev_stall) begin
          check("stall_hold_valid", m_valid, 1);
          check("stall_hold_data", m_data, prev_data);
        end
        if (m_valid) valid_count++;
        if (m_valid && m_ready) begin
          if (hs_count == 0) begin
            first_word   = m_data;
            first_hs_cyc = cyc;
          end
          hs_count++;
          if (m_last) last_count++;
          if (exp_q.size() == 0) begin
            check("extra_word", hs_count, 0);
          end else begin
            exp_w = exp_q.pop_front();
            check("word", m_data, exp_w);
            check("last_flag", m_last, exp_q.size() == 0);
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        if (done) begin
          done_count++;
          done_cyc = cyc;
        end
      end
    end
  end

  // ---------------- stream back-pressure driver ----------------
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- drain driver ----------------
  // abort_after > 0: reset is asserted once that many words have been seen.
  task automatic run_drain(input int base, input int rows, input bit rnd, input bit noise,
                           input int abort_after);
    bit got;
    bit noise_sent;
    int budget;
    build_expect(base, rows);
    clear_mon();
    rand_ready = rnd;
    budget = 100 + rows * NB * 40;
    @(posedge clk);
    #1;
    base_addr = AW'(base);
    num_rows  = (AW + 1)'(rows);
    start     = 1'b1;
    start_cyc = cyc;
    got = 1'b0;
    noise_sent = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (abort_after > 0 && hs_count >= abort_after) break;
      if (noise && !noise_sent && hs_count >= 3) begin
        // start while busy must be ignored
        start      = 1'b1;
        base_addr  = AW'($urandom);
        num_rows   = (AW + 1)'($urandom_range(1, 5));
        noise_sent = 1'b1;
      end
      if (done) got = 1'b1;
    end

    if (abort_after > 0) begin
      check("abort_reached", (hs_count >= abort_after), 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_read_mode", ext_read_mode, 0);
      check("rst_read_addr", (ext_read_addr_flat == '0), 1);
      check("rst_valid", m_valid, 0);
      check("rst_data", m_data, 0);
      check("rst_last", m_last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rand_ready = 1'b0;
      return;
    end

    check("done_seen", got, 1);
    if (noise) begin
      // start during the DONE cycle must be ignored as well
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      check("start_in_done_ignored", busy, 0);
    end else begin
      repeat (2) @(posedge clk);
      #1;
    end
    rand_ready = 1'b0;

    check("words_left", exp_q.size(), 0);
    check("word_count", hs_count, rows * NB);
    check("valid_cycles_min", (valid_count >= rows * NB), 1);
    check("last_count", last_count, (rows > 0) ? 1 : 0);
    check("done_count", done_count, 1);
    check("lane_addr_equal", lane_addr_bad, 0);
    if (rows == 0) begin
      check("empty_no_read", rd_count, 0);
      check("empty_no_valid", valid_count, 0);
    end else begin
      check("addr_count", addr_log.size(), exp_addr_q.size());
      for (int i = 0; i < exp_addr_q.size() && i < addr_log.size(); i++)
        check("row_addr", addr_log[i], exp_addr_q[i]);
    end
    if (!rnd) begin
      check("done_latency", done_cyc - start_cyc, 1 + rows * ROW_CYC);
      if (rows > 0) check("first_word_latency", first_hs_cyc - start_cyc, 3);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    num_rows  = '0;

    for (int a = 0; a < DEPTH; a++)
      for (int k = 0; k < NB; k++) mem[a][k] = DW'($urandom);
    for (int k = 0; k < NB; k++) mem[0][k] = DW'(k + 1);
    mem[5][0] = 16'hFFF0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_read_mode", ext_read_mode, 0);
    check("reset_valid", m_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_data", m_data, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // single row, lane k holds k+1, no back-pressure
    run_drain(0, 1, 1'b0, 1'b0, 0);
    check("row0_first_word", first_word, 1);

    // wrap across the top of the address space
    run_drain(510, 3, 1'b0, 1'b0, 0);
    // same drain under random back-pressure and stray starts
    run_drain(510, 3, 1'b1, 1'b1, 0);

    // empty drain
    run_drain(100, 0, 1'b0, 1'b0, 0);

    // reset mid-drain, then a clean drain of the same rows
    run_drain(7, 2, 1'b0, 1'b0, 5);
    run_drain(7, 2, 1'b0, 1'b0, 0);

    // negative lane word
    run_drain(5, 1, 1'b0, 1'b0, 0);
    check("relu_word", first_word, RELU_EXP);

    // randomized drains
    for (int t = 0; t < 4; t++)
      run_drain($urandom_range(0, DEPTH - 1), $urandom_range(1, 4), 1'b1, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
